atm_pin_entry: RTL and testbench

//  Keypad PIN collector/verifier upstream of the ATM session FSM. Accepts keypad codes over a

---
 rtl/atm_pkg.sv | 22 ++
 rtl/atm_idle_timer.sv | 35 +++
 rtl/atm_pin_entry.sv | 181 ++++++++++++++++++
 tb/tb_atm_pin_entry.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared types and key codes for the ATM PIN entry block
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANTED = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t KEY_CLEAR  = 4'hA;
    localparam digit_t KEY_ENTER  = 4'hB;
    localparam digit_t KEY_CANCEL = 4'hC;

    function automatic logic is_digit(input digit_t code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// rtl/atm_idle_timer.sv - loadable down-counter flagging inactivity expiry
module atm_idle_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/atm_pin_entry.sv
// rtl/atm_pin_entry.sv - keypad PIN collector/verifier with attempt counting and card lock
// Optional inactivity timeout in COLLECT enabled by ATM_PIN_TIMEOUT_EN.
module atm_pin_entry
    import atm_pkg::*;
#(
    parameter  int NUM_DIGITS     = 4,
    parameter  int MAX_TRIES      = 3,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int TRY_W          = $clog2(MAX_TRIES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    card_valid,
    input  logic [7:0]              card_no,
    input  logic [4*NUM_DIGITS-1:0] ref_pin,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    key_ready,
    output logic                    pin_ok,
    output logic                    pin_fail,
    output logic                    card_locked,
    output logic [TRY_W-1:0]        tries_left,
    output logic                    timeout
);

    localparam int PW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ref_q, ref_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             lock_valid_q, lock_valid_d;
    logic [7:0]       lock_card_q, lock_card_d;
    logic             card_prev_q;
    logic             pin_ok_q, pin_ok_d;
    logic             pin_fail_q, pin_fail_d;
    logic             timeout_q, timeout_d;
    logic             key_acc;
    logic             tmr_expire;

    assign key_acc = key_valid && (state_q == ST_COLLECT);

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic tmr_load;

    // Reload whenever COLLECT is (re)entered or a key lands while staying there.
    assign tmr_load = (state_d == ST_COLLECT) && ((state_q != ST_COLLECT) || key_acc);

    atm_idle_timer #(.W(TW)) u_idle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .en_i       (state_q == ST_COLLECT),
        .load_val_i (TW'(TIMEOUT_CYCLES - 1)),
        .expire_o   (tmr_expire)
    );
`else
    // Constant low; the comparison only keeps the parameter referenced.
    assign tmr_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        ref_d        = ref_q;
        tries_d      = tries_q;
        lock_valid_d = lock_valid_q;
        lock_card_d  = lock_card_q;
        pin_ok_d     = 1'b0;
        pin_fail_d   = 1'b0;
        timeout_d    = 1'b0;

        if ((state_q != ST_IDLE) && !card_valid) begin
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (card_valid && !card_prev_q) begin
                        if (lock_valid_q && (card_no == lock_card_q)) begin
                            state_d = ST_LOCKED;
                            tries_d = '0;
                        end else begin
                            state_d = ST_COLLECT;
                            tries_d = TRY_W'(MAX_TRIES);
                            buf_d   = '0;
                            cnt_d   = '0;
                            ref_d   = ref_pin;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (key_acc) begin
                        if (is_digit(key_code)) begin
                            if (cnt_q < CW'(NUM_DIGITS)) begin
                                buf_d = {buf_q[PW-5:0], key_code};
                                cnt_d = cnt_q + 1'b1;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            buf_d = '0;
                            cnt_d = '0;
                        end else if (key_code == KEY_CANCEL) begin
                            state_d = ST_IDLE;
                            buf_d   = '0;
                            cnt_d   = '0;
                        end else if (key_code == KEY_ENTER) begin
                            state_d = ST_CHECK;
                        end
                    end else if (tmr_expire) begin
                        state_d   = ST_IDLE;
                        timeout_d = 1'b1;
                        buf_d     = '0;
                        cnt_d     = '0;
                    end
                end
                ST_CHECK: begin
                    if ((buf_q == ref_q) && (cnt_q == CW'(NUM_DIGITS))) begin
                        state_d  = ST_GRANTED;
                        pin_ok_d = 1'b1;
                    end else begin
                        pin_fail_d = 1'b1;
                        tries_d    = (tries_q == '0) ? '0 : tries_q - 1'b1;
                        buf_d      = '0;
                        cnt_d      = '0;
                        if (tries_q <= TRY_W'(1)) begin
                            state_d      = ST_LOCKED;
                            lock_valid_d = 1'b1;
                            lock_card_d  = card_no;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end
                ST_GRANTED, ST_LOCKED: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            tries_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_card_q  <= '0;
            card_prev_q  <= 1'b0;
            pin_ok_q     <= 1'b0;
            pin_fail_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            ref_q        <= ref_d;
            tries_q      <= tries_d;
            lock_valid_q <= lock_valid_d;
            lock_card_q  <= lock_card_d;
            card_prev_q  <= card_valid;
            pin_ok_q     <= pin_ok_d;
            pin_fail_q   <= pin_fail_d;
            timeout_q    <= timeout_d;
        end
    end

    assign key_ready   = (state_q == ST_COLLECT);
    assign card_locked = (state_q == ST_LOCKED);
    assign pin_ok      = pin_ok_q;
    assign pin_fail    = pin_fail_q;
    assign timeout     = timeout_q;
    assign tries_left  = tries_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// tb/tb_atm_pin_entry.sv - directed self-checking bench for atm_pin_entry
module tb_atm_pin_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_valid = 1'b0;
    logic [7:0]  card_no = 8'h00;
    logic [15:0] ref_pin = 16'h1234;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_ready, pin_ok, pin_fail, card_locked, timeout;
    logic [1:0]  tries_left;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    atm_pin_entry #(.NUM_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .card_valid  (card_valid),
        .card_no     (card_no),
        .ref_pin     (ref_pin),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .pin_ok      (pin_ok),
        .pin_fail    (pin_fail),
        .card_locked (card_locked),
        .tries_left  (tries_left),
        .timeout     (timeout)
    );

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic insert(input logic [7:0] n);
        @(negedge clk);
        card_no    = n;
        card_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic remove();
        @(negedge clk);
        card_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_ready, pin_ok, pin_fail, card_locked, timeout, tries_left} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {key_ready, pin_ok, pin_fail, card_locked, timeout, tries_left});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_grant();
        insert(8'h5A);
        checks++;
        if (key_ready !== 1'b1 || tries_left !== 2'd3) begin
            failures++;
            $display("FAIL grant_collect key_ready=%b tries=%0d exp 1/3", key_ready, tries_left);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        checks++;
        if (pin_ok !== 1'b0) begin
            failures++;
            $display("FAIL grant_early pin_ok=%b exp 0", pin_ok);
        end
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b1 || pin_fail !== 1'b0) begin
            failures++;
            $display("FAIL grant_pulse pin_ok=%b pin_fail=%b exp 1/0", pin_ok, pin_fail);
        end
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b0 || key_ready !== 1'b0 || card_locked !== 1'b0 || tries_left !== 2'd3) begin
            failures++;
            $display("FAIL grant_hold pin_ok=%b key_ready=%b locked=%b tries=%0d exp 0/0/0/3",
                     pin_ok, key_ready, card_locked, tries_left);
        end
        remove();
    endtask

    task automatic test_clear_overflow();
        insert(8'h5A);
        press(4'd1); press(4'd2); press(4'hA);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'hB);
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b1 || pin_fail !== 1'b0) begin
            failures++;
            $display("FAIL clear_overflow pin_ok=%b pin_fail=%b exp 1/0", pin_ok, pin_fail);
        end
        remove();
    endtask

    task automatic test_short_entry();
        insert(8'h5A);
        press(4'd1); press(4'd2); press(4'd3); press(4'hB);
        @(negedge clk);
        checks++;
        if (pin_fail !== 1'b1 || pin_ok !== 1'b0 || tries_left !== 2'd2 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL short_entry fail=%b ok=%b tries=%0d ready=%b exp 1/0/2/1",
                     pin_fail, pin_ok, tries_left, key_ready);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b1) begin
            failures++;
            $display("FAIL short_then_good pin_ok=%b exp 1", pin_ok);
        end
        remove();
    endtask

    task automatic test_removal();
        insert(8'h5A);
        press(4'd1); press(4'd2);
        @(negedge clk);
        card_valid = 1'b0;
        key_valid  = 1'b1;
        key_code   = 4'd3;
        @(negedge clk);
        key_valid = 1'b0;
        checks++;
        if (key_ready !== 1'b0) begin
            failures++;
            $display("FAIL removal_idle key_ready=%b exp 0", key_ready);
        end
        insert(8'h5A);
        checks++;
        if (tries_left !== 2'd3) begin
            failures++;
            $display("FAIL removal_tries tries=%0d exp 3", tries_left);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b1) begin
            failures++;
            $display("FAIL removal_buffer_cleared pin_ok=%b exp 1", pin_ok);
        end
        remove();
    endtask

    task automatic test_reset_in_check();
        insert(8'h5A);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        rst_n      = 1'b0;
        card_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({key_ready, pin_ok, pin_fail, card_locked, timeout, tries_left} !== 7'b0) begin
            failures++;
            $display("FAIL reset_in_check got=%b exp=0000000",
                     {key_ready, pin_ok, pin_fail, card_locked, timeout, tries_left});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pin_ok !== 1'b0 || key_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_check_after ok=%b ready=%b exp 0/0", pin_ok, key_ready);
        end
    endtask

    task automatic test_lockout();
        logic [1:0] exp_tries;
        insert(8'h5A);
        for (int i = 0; i < 3; i++) begin
            press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'hB);
            @(negedge clk);
            exp_tries = 2'(2 - i);
            checks++;
            if (pin_fail !== 1'b1 || tries_left !== exp_tries) begin
                failures++;
                $display("FAIL lock_attempt%0d fail=%b tries=%0d exp 1/%0d",
                         i, pin_fail, tries_left, exp_tries);
            end
            checks++;
            if (card_locked !== (i == 2) || key_ready !== (i != 2)) begin
                failures++;
                $display("FAIL lock_state%0d locked=%b ready=%b exp %0d/%0d",
                         i, card_locked, key_ready, (i == 2), (i != 2));
            end
        end
        remove();
        insert(8'h5A);
        checks++;
        if (card_locked !== 1'b1 || key_ready !== 1'b0) begin
            failures++;
            $display("FAIL lock_reinsert locked=%b ready=%b exp 1/0", card_locked, key_ready);
        end
        remove();
        insert(8'h33);
        checks++;
        if (card_locked !== 1'b0 || key_ready !== 1'b1 || tries_left !== 2'd3) begin
            failures++;
            $display("FAIL lock_other_card locked=%b ready=%b tries=%0d exp 0/1/3",
                     card_locked, key_ready, tries_left);
        end
        remove();
    endtask

    task automatic test_timeout();
        int seen;
        seen = 0;
        @(negedge clk);
        card_no    = 8'h33;
        card_valid = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (timeout !== 1'b0 || key_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL timeout_early bad_cycles=%0d exp 0", seen);
        end
        @(negedge clk);
`ifdef ATM_PIN_TIMEOUT_EN
        checks++;
        if (timeout !== 1'b1 || key_ready !== 1'b0 || pin_fail !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse timeout=%b ready=%b fail=%b exp 1/0/0",
                     timeout, key_ready, pin_fail);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_one_cycle timeout=%b exp 0", timeout);
        end
`else
        repeat (20) @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout timeout=%b ready=%b exp 0/1", timeout, key_ready);
        end
`endif
        remove();
    endtask

    initial begin
        test_reset();
        test_grant();
        test_clear_overflow();
        test_short_entry();
        test_removal();
        test_reset_in_check();
        test_lockout();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
